// File: rtl/sram_arbiter.sv
// Two-requester arbiter for a single-port SRAM. Round-robin arbitration,
// optional locked bursts capped at MAX_BURST grants while the other side is
// waiting, combinational grant and SRAM drive, and read data returned one
// cycle after the grant.
//
// state | meaning
// ARB   | no ownership, round-robin between requesters
// LOCK0 | requester 0 owns the SRAM for a locked burst
// LOCK1 | requester 1 owns the SRAM for a locked burst
module sram_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_0,
    input  logic                  i_req_1,
    input  logic                  i_we_0,
    input  logic                  i_we_1,
    input  logic                  i_lock_0,
    input  logic                  i_lock_1,
    input  logic [ADDR_WIDTH-1:0] i_addr_0,
    input  logic [ADDR_WIDTH-1:0] i_addr_1,
    input  logic [31:0]           i_wdata_0,
    input  logic [31:0]           i_wdata_1,
    output logic                  o_gnt_0,
    output logic                  o_gnt_1,
    output logic                  o_rvalid_0,
    output logic                  o_rvalid_1,
    output logic [31:0]           o_rdata_0,
    output logic [31:0]           o_rdata_1,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_write,
    output logic [31:0]           o_mem_wdata,
    input  logic [31:0]           i_mem_rdata
);

    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t        state;
    logic          last_winner;
    logic [CW-1:0] burst_cnt;

    logic          burst_full;
    logic          gnt_0;
    logic          gnt_1;
    logic          locked_hold;
    logic          arb_lw;

    assign burst_full = (burst_cnt == CW'(MAX_BURST));

    // Grant decision: honour the current lock holder unless its burst is
    // exhausted and the other side is waiting, else fall back to round-robin
    // in the same cycle so a lock release costs no dead cycle.
    always_comb begin
        gnt_0       = 1'b0;
        gnt_1       = 1'b0;
        locked_hold = 1'b0;
        arb_lw      = last_winner;
        case (state)
            LOCK0: begin
                if (i_req_0 && i_lock_0 && !(burst_full && i_req_1)) begin
                    gnt_0       = 1'b1;
                    locked_hold = 1'b1;
                end else begin
                    arb_lw = 1'b0;
                end
            end
            LOCK1: begin
                if (i_req_1 && i_lock_1 && !(burst_full && i_req_0)) begin
                    gnt_1       = 1'b1;
                    locked_hold = 1'b1;
                end else begin
                    arb_lw = 1'b1;
                end
            end
            default: ;
        endcase
        if (!locked_hold) begin
            if (i_req_0 && !i_req_1) begin
                gnt_0 = 1'b1;
            end else if (i_req_1 && !i_req_0) begin
                gnt_1 = 1'b1;
            end else if (i_req_0 && i_req_1) begin
                if (arb_lw) begin
                    gnt_0 = 1'b1;
                end else begin
                    gnt_1 = 1'b1;
                end
            end
        end
        // Reset is asynchronous; keep the SRAM untouched while it is held.
        if (i_rst) begin
            gnt_0 = 1'b0;
            gnt_1 = 1'b0;
        end
    end

    assign o_gnt_0 = gnt_0;
    assign o_gnt_1 = gnt_1;

    // SRAM drive comes from the winner; idle bus is all zeros.
    always_comb begin
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_write = 1'b0;
        if (gnt_0) begin
            o_mem_addr  = i_addr_0;
            o_mem_wdata = i_wdata_0;
            o_mem_write = i_we_0;
        end else if (gnt_1) begin
            o_mem_addr  = i_addr_1;
            o_mem_wdata = i_wdata_1;
            o_mem_write = i_we_1;
        end
    end

    // Ownership FSM with round-robin pointer and saturating burst counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= ARB;
            last_winner <= 1'b1;
            burst_cnt   <= '0;
        end else if (gnt_0 || gnt_1) begin
            last_winner <= gnt_1;
            if (locked_hold) begin
                if (!burst_full) begin
                    burst_cnt <= burst_cnt + CW'(1);
                end
            end else if (gnt_0 && i_lock_0) begin
                state     <= LOCK0;
                burst_cnt <= CW'(1);
            end else if (gnt_1 && i_lock_1) begin
                state     <= LOCK1;
                burst_cnt <= CW'(1);
            end else begin
                state     <= ARB;
                burst_cnt <= '0;
            end
        end else begin
            state     <= ARB;
            burst_cnt <= '0;
        end
    end

    // Read return path: capture at the grant edge, pulse valid for one cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rvalid_0 <= 1'b0;
            o_rvalid_1 <= 1'b0;
            o_rdata_0  <= '0;
            o_rdata_1  <= '0;
        end else begin
            o_rvalid_0 <= gnt_0 && !i_we_0;
            o_rvalid_1 <= gnt_1 && !i_we_1;
            if (gnt_0 && !i_we_0) begin
                o_rdata_0 <= i_mem_rdata;
            end
            if (gnt_1 && !i_we_1) begin
                o_rdata_1 <= i_mem_rdata;
            end
        end
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, SRAM word-address width.
REQ-002 SHALL have parameter MAX_BURST, default 4, max consecutive locked grants before forced yield (>=2).
REQ-003 SHALL have port i_clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port i_rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports i_req_0 / i_req_1  in  1  access request, requester n.
REQ-006 SHALL have ports i_we_0 / i_we_1  in  1  1=write, 0=read, qualified by i_req_n.
REQ-007 SHALL have ports i_lock_0 / i_lock_1  in  1  request to hold ownership for a burst.
REQ-008 SHALL have ports i_addr_0 / i_addr_1  in  ADDR_WIDTH  word address.
REQ-009 SHALL have ports i_wdata_0 / i_wdata_1  in  32  write data.
REQ-010 SHALL have ports o_gnt_0 / o_gnt_1  out  1  access performed this cycle (combinational).
REQ-011 SHALL have ports o_rvalid_0 / o_rvalid_1  out  1  one-cycle pulse, o_rdata_n valid.
REQ-012 SHALL have ports o_rdata_0 / o_rdata_1  out  32  registered read data.
REQ-013 SHALL have ports o_mem_addr  out  ADDR_WIDTH; o_mem_write  out  1; o_mem_wdata  out  32: single-port SRAM drive.
REQ-014 SHALL have port i_mem_rdata  in  32  SRAM combinational read data for o_mem_addr.

Function
REQ-015 SHALL grant at most one requester per cycle; o_gnt_n=1 only if i_req_n=1.
REQ-016 SHALL keep registers state {ARB, LOCK0, LOCK1}, last_winner (1 bit), burst_cnt (0..MAX_BURST, saturating).
REQ-017 SHALL in ARB: single requester wins; both requesting -> requester != last_winner wins; none -> no grant.
REQ-018 SHALL in LOCKn grant n iff i_req_n & i_lock_n & !(burst_cnt==MAX_BURST & i_req_other); otherwise apply REQ-017 rule same cycle with last_winner=n (no dead cycle).
REQ-019 SHALL update last_winner to the granted index on every grant; unchanged when no grant.
REQ-020 SHALL transition: grant to n with i_lock_n=1 from ARB or from other's lock -> LOCKn, burst_cnt=1; locked grant in LOCKn -> stay, burst_cnt+1 saturating at MAX_BURST; LOCKn with no locked grant -> ARB (or LOCKm per first clause), burst_cnt=0 on ARB.
REQ-021 SHALL hold lock with burst_cnt saturated while other requester idle (no forced release without contention).
REQ-022 SHALL drive o_mem_addr/o_mem_wdata from winner, o_mem_write = gnt & i_we_winner; no grant -> o_mem_addr=0, o_mem_wdata=0, o_mem_write=0.
REQ-023 SHALL on granted read capture i_mem_rdata into o_rdata_n at that clock edge and assert o_rvalid_n for exactly the next cycle (latency 1); o_rdata_n holds otherwise.
REQ-024 SHALL not assert o_rvalid_n for granted writes; write completes at the grant-cycle edge.
REQ-025 SHALL support back-to-back reads by one requester at one access per cycle, rvalid pulsing every cycle.
REQ-026 SHALL treat read and write of same address in consecutive cycles as ordered: read after write returns new data.

Reset
REQ-027 SHALL on i_rst=1 immediately set state=ARB, last_winner=1, burst_cnt=0, o_rvalid_n=0, o_rdata_n=0.
REQ-028 SHALL force o_gnt_n=0 and o_mem_write=0 while i_rst=1, regardless of requests.
REQ-029 SHALL on reset mid-burst or with read pending discard lock and pending rvalid; first grant after release goes to requester 0 if both request.

Verification
REQ-030 Both req read, addr0=0x10, addr1=0x20, after reset -> gnt_0 cycle 1, gnt_1 cycle 2, rvalid each one cycle after own grant with SRAM contents.
REQ-031 Req0 write 0xDEADBEEF @0x05, next cycle req1 read @0x05 -> o_rdata_1=0xDEADBEEF, o_rvalid_1 one cycle after gnt_1.
REQ-032 Req0 locked burst, req1 continuously requesting, MAX_BURST=4 -> gnt_0 x4, then gnt_1, then round-robin.
REQ-033 Req0 locked 10 cycles, req1 idle -> gnt_0 all 10 cycles, burst_cnt saturates at 4, no bubbles.
REQ-034 i_rst asserted mid-lock with read pending -> o_rvalid_0=0, o_gnt=0, o_mem_write=0 same cycle; after release both req -> gnt_0 first.
REQ-035 No requests -> o_mem_write=0, o_mem_addr=0, no grants, state stays ARB.
